// File: rtl/mandel_scan_engine.sv
// Mandelbrot escape-iteration scan engine. It raster-scans a programmable viewport, iterates
// z = z^2 + c once per cycle, and streams one iteration count per pixel over valid/ready.
module mandel_scan_engine #(
  parameter int BITS       = 16,
  parameter int ITER_W     = 4,
  parameter int MAX_ITER   = 15,
  parameter int H_PIXELS   = 160,
  parameter int V_PIXELS   = 120,
  parameter int X_LEFT_DEF = -11 << (BITS - 5),
  parameter int Y_TOP_DEF  = 13 << (BITS - 6),
  parameter int X_INC_DEF  = 240,
  parameter int Y_INC_DEF  = 51
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        continuous,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_sel,
  input  logic [BITS-1:0]             cfg_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [ITER_W-1:0]           pix_iter,
  output logic [$clog2(H_PIXELS)-1:0] pix_col,
  output logic [$clog2(V_PIXELS)-1:0] pix_row,
  output logic                        pix_eol,
  output logic                        pix_eof,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int COL_W = $clog2(H_PIXELS);
  localparam int ROW_W = $clog2(V_PIXELS);
  localparam int FRAC  = BITS - 3;
  localparam int PW    = 2 * BITS + 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StInit = 3'd2;
  localparam logic [2:0] StIter = 3'd3;
  localparam logic [2:0] StOut  = 3'd4;

  // 4.0 expressed in the full-precision product format (2*FRAC fraction bits)
  localparam logic signed [PW-1:0] Four = PW'(1) <<< (2 * FRAC + 2);

  logic [2:0] state_q, state_d;

  logic signed [BITS-1:0] sh_x_left_q, sh_y_top_q, act_x_left_q, act_y_top_q;
  logic        [BITS-1:0] sh_x_inc_q, sh_y_inc_q, act_x_inc_q, act_y_inc_q;

  logic signed [BITS-1:0] x_q, y_q, x0_q, y0_q;
  logic        [ITER_W-1:0] iter_q, pix_iter_q;
  logic        [COL_W-1:0]  col_q;
  logic        [ROW_W-1:0]  row_q;
  logic                     frame_done_q;

  logic signed [PW-1:0]   x_ext, y_ext, x2, y2, xy, mag;
  logic signed [BITS-1:0] x_next, y_next;
  logic escape, iter_max, last_col, last_row, hs, frame_start;

  assign x_ext = PW'(x_q);
  assign y_ext = PW'(y_q);
  assign x2    = x_ext * x_ext;
  assign y2    = y_ext * y_ext;
  assign xy    = x_ext * y_ext;
  assign mag   = x2 + y2;

  assign escape   = (mag >= Four);
  assign iter_max = (iter_q == ITER_W'(MAX_ITER));

  // Rescale back to Q3 and wrap to BITS; no saturation.
  assign x_next = BITS'((x2 - y2) >>> FRAC) + x0_q;
  assign y_next = BITS'((xy <<< 1) >>> FRAC) + y0_q;

  assign last_col    = (col_q == COL_W'(H_PIXELS - 1));
  assign last_row    = (row_q == ROW_W'(V_PIXELS - 1));
  assign pix_valid   = (state_q == StOut);
  assign hs          = pix_valid && pix_ready;
  assign frame_start = ((state_q == StIdle) && start) || (hs && last_col && last_row && continuous);

  assign pix_iter   = pix_iter_q;
  assign pix_col    = col_q;
  assign pix_row    = row_q;
  assign pix_eol    = pix_valid && last_col;
  assign pix_eof    = pix_valid && last_col && last_row;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = StInit;
      StInit: state_d = StIter;
      StIter: if (escape || iter_max) state_d = StOut;
      StOut: begin
        if (pix_ready) begin
          if (!(last_col && last_row)) state_d = StInit;
          else if (continuous)         state_d = StLoad;
          else                         state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_done_q <= 1'b0;
      sh_x_left_q  <= BITS'(X_LEFT_DEF);
      sh_y_top_q   <= BITS'(Y_TOP_DEF);
      sh_x_inc_q   <= BITS'(X_INC_DEF);
      sh_y_inc_q   <= BITS'(Y_INC_DEF);
      act_x_left_q <= BITS'(X_LEFT_DEF);
      act_y_top_q  <= BITS'(Y_TOP_DEF);
      act_x_inc_q  <= BITS'(X_INC_DEF);
      act_y_inc_q  <= BITS'(Y_INC_DEF);
      x_q          <= '0;
      y_q          <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      iter_q       <= '0;
      pix_iter_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= hs && last_col && last_row;

      if (cfg_we) begin
        case (cfg_sel)
          2'd0: sh_x_left_q <= cfg_data;
          2'd1: sh_y_top_q  <= cfg_data;
          2'd2: sh_x_inc_q  <= cfg_data;
          2'd3: sh_y_inc_q  <= cfg_data;
        endcase
      end

      // Snapshot taken on the start edge itself, so a same-cycle write lands next frame.
      if (frame_start) begin
        act_x_left_q <= sh_x_left_q;
        act_y_top_q  <= sh_y_top_q;
        act_x_inc_q  <= sh_x_inc_q;
        act_y_inc_q  <= sh_y_inc_q;
      end

      case (state_q)
        StLoad: begin
          x0_q  <= act_x_left_q;
          y0_q  <= act_y_top_q;
          col_q <= '0;
          row_q <= '0;
        end
        StInit: begin
          x_q    <= x0_q;
          y_q    <= y0_q;
          iter_q <= '0;
        end
        StIter: begin
          if (escape || iter_max) begin
            pix_iter_q <= iter_q;
          end else begin
            x_q    <= x_next;
            y_q    <= y_next;
            iter_q <= iter_q + 1'b1;
          end
        end
        StOut: begin
          if (pix_ready) begin
            if (!last_col) begin
              col_q <= col_q + 1'b1;
              x0_q  <= x0_q + act_x_inc_q;
            end else if (!last_row) begin
              col_q <= '0;
              x0_q  <= act_x_left_q;
              row_q <= row_q + 1'b1;
              y0_q  <= y0_q - act_y_inc_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_scan_engine.sv
// Directed bench for mandel_scan_engine on a small 4x3 viewport; expected pixels come from
// a fixed-point reference model and are queued per frame, then popped as the DUT emits them.
module tb_mandel_scan_engine;

  localparam int BITS     = 16;
  localparam int FRAC     = BITS - 3;
  localparam int MAX_ITER = 15;
  localparam int H        = 4;
  localparam int V        = 3;
  localparam int NPIX     = H * V;
  localparam int BUDGET   = 100;

  localparam int XL_DEF = -22528;  // -2.75
  localparam int YT_DEF = 13312;   // 1.625
  localparam int XI_DEF = 240;
  localparam int YI_DEF = 51;

  logic clk = 1'b0;
  logic rst, start, continuous, cfg_we, pix_ready;
  logic [1:0] cfg_sel;
  logic [BITS-1:0] cfg_data;
  logic pix_valid, pix_eol, pix_eof, busy, frame_done;
  logic [3:0] pix_iter;
  logic [1:0] pix_col;
  logic [1:0] pix_row;

  always #5 clk = ~clk;

  mandel_scan_engine #(
    .BITS     (BITS),
    .ITER_W   (4),
    .MAX_ITER (MAX_ITER),
    .H_PIXELS (H),
    .V_PIXELS (V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_iter   (pix_iter),
    .pix_col    (pix_col),
    .pix_row    (pix_row),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    int iter;
    int col;
    int row;
    int eol;
    int eof;
  } pix_t;

  pix_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  function automatic int ref_iter(input longint cx, input longint cy);
    longint x, y, x2, y2, xy, nx, ny;
    longint four;
    four = longint'(4) <<< (2 * FRAC);
    x = cx;
    y = cy;
    for (int k = 0; k <= MAX_ITER; k++) begin
      x2 = x * x;
      y2 = y * y;
      if (x2 + y2 >= four) return k;
      if (k == MAX_ITER) return k;
      xy = x * y;
      nx = wrap(((x2 - y2) >>> FRAC) + cx);
      ny = wrap(((2 * xy) >>> FRAC) + cy);
      x = nx;
      y = ny;
    end
    return MAX_ITER;
  endfunction

  task automatic push_frame(input int xl, input int yt, input int xi, input int yi);
    pix_t p;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        p.iter = ref_iter(wrap(xl + c * xi), wrap(yt - r * yi));
        p.col  = c;
        p.row  = r;
        p.eol  = (c == H - 1) ? 1 : 0;
        p.eof  = (c == H - 1 && r == V - 1) ? 1 : 0;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = 16'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_load", busy, 1);
  endtask

  // Waits for the next pixel (latency counted in negedges from INIT), compares it, then
  // optionally stalls it or issues an x_left write on its handshake edge.
  task automatic get_pix(input bit hold, input bit wr, input int wdata);
    pix_t e;
    int lat;
    bit seen, fd, stable;
    logic [3:0] it0;
    logic [1:0] c0, r0;
    lat = 0;
    seen = 0;
    fd = 0;
    while (!seen && lat < BUDGET) begin
      @(negedge clk);
      lat++;
      cfg_we = 1'b0;
      if (hold) pix_ready = 1'b0;
      if (frame_done === 1'b1) fd = 1;
      if (pix_valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      chk("pix_valid_timeout", pix_valid, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("pix_iter", pix_iter, e.iter);
    chk("pix_col", pix_col, e.col);
    chk("pix_row", pix_row, e.row);
    chk("pix_eol", pix_eol, e.eol);
    chk("pix_eof", pix_eof, e.eof);
    chk("latency", lat, e.iter + 3);
    chk("frame_done_midframe", fd, 0);
    if (hold) begin
      stable = 1;
      it0 = pix_iter;
      c0 = pix_col;
      r0 = pix_row;
      repeat (50) begin
        @(negedge clk);
        if (pix_valid !== 1'b1 || pix_iter !== it0 || pix_col !== c0 || pix_row !== r0)
          stable = 0;
      end
      chk("hold_stable", stable, 1);
      pix_ready = 1'b1;
    end
    if (wr) begin
      cfg_we   = 1'b1;
      cfg_sel  = 2'd0;
      cfg_data = 16'(wdata);
    end
  endtask

  task automatic run_frame(input int hold_idx, input int wa_idx, input int wa_data,
                           input int wb_idx, input int wb_data, input bit cont);
    continuous = cont;
    for (int i = 0; i < NPIX; i++)
      get_pix(i == hold_idx, (i == wa_idx) || (i == wb_idx), (i == wa_idx) ? wa_data : wb_data);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("frame_done", frame_done, 1);
    chk("busy_after_frame", busy, cont);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    cfg_we = 1'b0;
    cfg_sel = 2'd0;
    cfg_data = '0;
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_iter", pix_iter, 0);
    chk("rst_pix_col", pix_col, 0);
    chk("rst_pix_row", pix_row, 0);
    chk("rst_pix_eol", pix_eol, 0);
    chk("rst_pix_eof", pix_eof, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Default viewport, with a 50-cycle back-pressure stall on pixel 5
    push_frame(XL_DEF, YT_DEF, XI_DEF, YI_DEF);
    start_frame();
    run_frame(5, -1, 0, -1, 0, 0);

    // c = 0 everywhere: never escapes
    cfg_wr(2'd0, 0);
    cfg_wr(2'd1, 0);
    cfg_wr(2'd2, 0);
    cfg_wr(2'd3, 0);
    push_frame(0, 0, 0, 0);
    start_frame();
    run_frame(-1, -1, 0, -1, 0, 0);

    // c = (0.5, 0) and c = (-2.0, 0), the latter sitting exactly on |z|^2 = 4
    cfg_wr(2'd0, 4096);
    push_frame(4096, 0, 0, 0);
    start_frame();
    run_frame(-1, -1, 0, -1, 0, 0);
    cfg_wr(2'd0, -16384);
    push_frame(-16384, 0, 0, 0);
    start_frame();
    run_frame(-1, -1, 0, -1, 0, 0);

    // Continuous: x_left=-1.0 written mid-frame 1, x_left=-0.5 written on the wrap edge
    cfg_wr(2'd0, 0);
    cfg_wr(2'd1, 0);
    cfg_wr(2'd2, 2048);
    cfg_wr(2'd3, 2048);
    push_frame(0, 0, 2048, 2048);
    push_frame(-8192, 0, 2048, 2048);
    push_frame(-4096, 0, 2048, 2048);
    start_frame();
    run_frame(-1, 3, -8192, NPIX - 1, -4096, 1);
    run_frame(-1, -1, 0, -1, 0, 1);
    run_frame(-1, -1, 0, -1, 0, 0);

    // Reset while iterating
    cfg_wr(2'd0, 0);
    cfg_wr(2'd1, 0);
    cfg_wr(2'd2, 0);
    cfg_wr(2'd3, 0);
    start_frame();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_iter_valid", pix_valid, 0);
    chk("rst_iter_busy", busy, 0);
    chk("rst_iter_pix_iter", pix_iter, 0);

    // Reset while a pixel is being held in OUT
    cfg_wr(2'd0, 0);
    cfg_wr(2'd1, 0);
    cfg_wr(2'd2, 0);
    cfg_wr(2'd3, 0);
    start_frame();
    pix_ready = 1'b0;
    n = 0;
    while (pix_valid !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("out_reached", pix_valid, 1);
    chk("out_pix_iter", pix_iter, MAX_ITER);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pix_ready = 1'b1;
    chk("rst_out_valid", pix_valid, 0);
    chk("rst_out_busy", busy, 0);
    chk("rst_out_pix_iter", pix_iter, 0);
    chk("rst_out_frame_done", frame_done, 0);

    // Config must be back at defaults and start must work normally
    push_frame(XL_DEF, YT_DEF, XI_DEF, YI_DEF);
    start_frame();
    run_frame(-1, -1, 0, -1, 0, 0);
    chk("final_pix_valid", pix_valid, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
